// File: rtl/barrier_controller.sv
// Game-side controller for the barrier sprite: spawns barriers after a
// randomised cooldown, resolves each barrier as a collision or a dodge,
// and keeps score and lives. Runs entirely on the pixel clock.
module barrier_controller #(
    parameter int COOLDOWN_MIN       = 30,
    parameter int COOLDOWN_RAND_BITS = 6,
    parameter int LIVES_INIT         = 3,
    parameter int ARMED_TIMEOUT      = 120,
    parameter int HIT_HOLD           = 60,
    parameter int SCORE_W            = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_v_sync,
    input  logic               i_start,
    input  logic               i_player_hit,
    input  logic               i_barrier_hit,
    input  logic               i_in_position,
    output logic               o_active,
    output logic               o_collision,
    output logic               o_dodged,
    output logic [SCORE_W-1:0] o_score,
    output logic [2:0]         o_lives,
    output logic               o_game_over,
    output logic [2:0]         o_state
);

    // Wide enough for the largest of cooldown max (93), timeout (120) and hold (60).
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COOLDOWN  = 3'd1,
        ST_APPROACH  = 3'd2,
        ST_ARMED     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               collision_q, collision_d;
    logic               dodged_q, dodged_d;
    logic               active_q;
    logic               vs_q;
    logic [15:0]        lfsr_q;

    logic               frame_tick;
    logic               lfsr_fb;
    logic [CNT_W-1:0]   cooldown_load;

    // vs_q resets high so a v_sync held high through reset is not seen as an edge.
    assign frame_tick    = i_v_sync & ~vs_q;
    assign lfsr_fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign cooldown_load = CNT_W'(COOLDOWN_MIN) + CNT_W'(lfsr_q[COOLDOWN_RAND_BITS-1:0]);

    // Next-state, counter, score/lives and pulse decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        lives_d     = lives_q;
        collision_d = 1'b0;
        dodged_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (i_start) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = cooldown_load;
                    score_d = '0;
                    lives_d = 3'(LIVES_INIT);
                end
            end
            ST_COOLDOWN: begin
                if (frame_tick) begin
                    if (cnt_q == '0) state_d = ST_APPROACH;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_APPROACH: begin
                // Hit inputs are meaningless until the barrier is in position.
                if (i_in_position) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
            end
            ST_ARMED: begin
                if (i_player_hit && i_barrier_hit) begin
                    collision_d = 1'b1;
                    lives_d     = lives_q - 1'b1;
                    if (lives_q == 3'd1) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(HIT_HOLD);
                    end
                end else if (!i_in_position ||
                             (frame_tick && (cnt_q == CNT_W'(ARMED_TIMEOUT - 1)))) begin
                    // Barrier fell away, or stayed up too long: either way the player survived.
                    dodged_d = 1'b1;
                    score_d  = (score_q == '1) ? score_q : score_q + 1'b1;
                    state_d  = ST_COOLDOWN;
                    cnt_d    = cooldown_load;
                end else if (frame_tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = cooldown_load;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, registered outputs, v_sync edge detector and LFSR.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            score_q     <= '0;
            lives_q     <= 3'(LIVES_INIT);
            collision_q <= 1'b0;
            dodged_q    <= 1'b0;
            active_q    <= 1'b0;
            vs_q        <= 1'b1;
            lfsr_q      <= 16'hACE1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            collision_q <= collision_d;
            dodged_q    <= dodged_d;
            // Registered from the next state so o_active tracks the state it belongs to.
            active_q    <= (state_d == ST_APPROACH) || (state_d == ST_ARMED);
            vs_q        <= i_v_sync;
            lfsr_q      <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign o_active    = active_q;
    assign o_collision = collision_q;
    assign o_dodged    = dodged_q;
    assign o_score     = score_q;
    assign o_lives     = lives_q;
    assign o_game_over = (state_q == ST_GAME_OVER);
    assign o_state     = state_q;

endmodule

// File: tb/tb_barrier_controller.sv
// Directed self-checking bench for barrier_controller.
module tb_barrier_controller;

    logic       clk = 1'b0;
    logic       rst, v_sync, start, player_hit, barrier_hit, in_position;
    logic       active, collision, dodged, game_over;
    logic [7:0] score;
    logic [2:0] lives, state;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr;
    int          n_expect;
    int          cnt;

    always #5 clk = ~clk;

    barrier_controller dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_v_sync     (v_sync),
        .i_start      (start),
        .i_player_hit (player_hit),
        .i_barrier_hit(barrier_hit),
        .i_in_position(in_position),
        .o_active     (active),
        .o_collision  (collision),
        .o_dodged     (dodged),
        .o_score      (score),
        .o_lives      (lives),
        .o_game_over  (game_over),
        .o_state      (state)
    );

    // Independent LFSR reference (taps 16,14,13,11) to predict the cooldown length.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic tick;
        v_sync = 1'b1;
        step();
        v_sync = 1'b0;
        step();
    endtask

    // Wait through cooldown until the barrier spawns, then report it in position.
    task automatic to_armed;
        for (int k = 0; k < 100 && !active; k++) tick();
        chk("spawn_active", {31'd0, active}, 32'd1);
        in_position = 1'b1;
        step();
        chk("armed_state", {29'd0, state}, 32'd3);
    endtask

    task automatic collide;
        player_hit  = 1'b1;
        barrier_hit = 1'b1;
        step();
        player_hit  = 1'b0;
        barrier_hit = 1'b0;
        in_position = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v_sync = 1'b1; start = 1'b0;
        player_hit = 1'b0; barrier_hit = 1'b0; in_position = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1. reset state, v_sync held high throughout
        chk("rst_state",     {29'd0, state},     32'd0);
        chk("rst_active",    {31'd0, active},    32'd0);
        chk("rst_collision", {31'd0, collision}, 32'd0);
        chk("rst_dodged",    {31'd0, dodged},    32'd0);
        chk("rst_score",     {24'd0, score},     32'd0);
        chk("rst_lives",     {29'd0, lives},     32'd3);
        chk("rst_game_over", {31'd0, game_over}, 32'd0);

        // 2. start; cooldown of N+1 ticks with N = 30 + LFSR[5:0]
        start = 1'b1;
        n_expect = 30 + int'(m_lfsr[5:0]);
        step();
        start = 1'b0;
        chk("start_state", {29'd0, state}, 32'd1);
        v_sync = 1'b0;
        step();
        cnt = 0;
        while (!active && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("cooldown_ticks", cnt, n_expect + 1);
        chk("approach_state", {29'd0, state}, 32'd2);

        // 3. in position for 5 frames, then fall -> dodge
        in_position = 1'b1;
        step();
        chk("armed_state0", {29'd0, state}, 32'd3);
        repeat (5) tick();
        chk("armed_after5", {29'd0, state}, 32'd3);
        chk("no_early_dodge", {31'd0, dodged}, 32'd0);
        in_position = 1'b0;
        step();
        chk("dodge_pulse", {31'd0, dodged}, 32'd1);
        chk("dodge_score", {24'd0, score}, 32'd1);
        chk("dodge_active", {31'd0, active}, 32'd0);
        chk("dodge_state", {29'd0, state}, 32'd1);
        step();
        chk("dodge_pulse_end", {31'd0, dodged}, 32'd0);

        // 4. collision -> HOLD for 61 ticks
        to_armed();
        collide();
        chk("coll_pulse", {31'd0, collision}, 32'd1);
        chk("coll_lives", {29'd0, lives}, 32'd2);
        chk("coll_state", {29'd0, state}, 32'd4);
        chk("coll_active", {31'd0, active}, 32'd0);
        step();
        chk("coll_pulse_end", {31'd0, collision}, 32'd0);
        repeat (60) tick();
        chk("hold_60_state", {29'd0, state}, 32'd4);
        chk("hold_60_active", {31'd0, active}, 32'd0);
        tick();
        chk("hold_done_state", {29'd0, state}, 32'd1);

        // 5. two more collisions -> game over, then restart
        to_armed();
        collide();
        chk("coll2_lives", {29'd0, lives}, 32'd1);
        repeat (61) tick();
        to_armed();
        collide();
        chk("go_lives", {29'd0, lives}, 32'd0);
        chk("go_flag", {31'd0, game_over}, 32'd1);
        chk("go_state", {29'd0, state}, 32'd5);
        repeat (5) tick();
        chk("go_active", {31'd0, active}, 32'd0);
        chk("go_state_held", {29'd0, state}, 32'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_score", {24'd0, score}, 32'd0);
        chk("restart_lives", {29'd0, lives}, 32'd3);
        chk("restart_state", {29'd0, state}, 32'd1);
        chk("restart_go", {31'd0, game_over}, 32'd0);

        // 6a. collision and in_position fall together -> collision only
        to_armed();
        player_hit = 1'b1; barrier_hit = 1'b1; in_position = 1'b0;
        step();
        player_hit = 1'b0; barrier_hit = 1'b0;
        chk("prio_coll", {31'd0, collision}, 32'd1);
        chk("prio_no_dodge", {31'd0, dodged}, 32'd0);
        chk("prio_lives", {29'd0, lives}, 32'd2);
        chk("prio_state", {29'd0, state}, 32'd4);
        step();
        chk("prio_no_dodge_later", {31'd0, dodged}, 32'd0);
        repeat (61) tick();

        // 6b. in_position held for 120 ticks -> forced dodge
        to_armed();
        repeat (119) tick();
        chk("timeout_119_state", {29'd0, state}, 32'd3);
        chk("timeout_119_dodged", {31'd0, dodged}, 32'd0);
        v_sync = 1'b1;
        step();
        chk("timeout_dodge", {31'd0, dodged}, 32'd1);
        chk("timeout_state", {29'd0, state}, 32'd1);
        chk("timeout_score", {24'd0, score}, 32'd1);
        v_sync = 1'b0;
        step();
        chk("timeout_dodge_end", {31'd0, dodged}, 32'd0);
        in_position = 1'b0;

        // 6c. dodge up to 255, then one more -> score saturates
        for (int d = 0; d < 254; d++) begin
            to_armed();
            in_position = 1'b0;
            step();
        end
        chk("score_255", {24'd0, score}, 32'd255);
        to_armed();
        in_position = 1'b0;
        step();
        chk("sat_dodge", {31'd0, dodged}, 32'd1);
        chk("sat_score", {24'd0, score}, 32'd255);

        // Reset mid-operation while armed
        to_armed();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_position = 1'b0;
        chk("midrst_active", {31'd0, active}, 32'd0);
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_score", {24'd0, score}, 32'd0);
        chk("midrst_lives", {29'd0, lives}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/barrier_controller.md
Name: barrier_controller

Overview:
- Game-side controller at the other end of the barrier sprite interface.
- Decides when a barrier spawns by driving the sprite's `active` input, and waits for the sprite's `in_position` flag.
- Resolves each barrier as a collision or a dodge, using per-pixel coincidence of the player sprite hit and the barrier sprite hit.
- Keeps score and lives, and runs on the pixel clock.

Parameters:
- COOLDOWN_MIN, 30: minimum frames between a barrier resolving and the next spawn.
- COOLDOWN_RAND_BITS, 6: number of LFSR bits added to COOLDOWN_MIN (extra 0..63 frames).
- LIVES_INIT, 3: lives at game start (max 7).
- ARMED_TIMEOUT, 120: frames in ARMED with no in_position fall before a forced dodge.
- HIT_HOLD, 60: frames the barrier is kept retracted after a collision.
- SCORE_W, 8: score width.

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  synchronous, active-high reset
- i_v_sync  in  1  vertical sync level, treated as a data signal
- i_start  in  1  start/restart request, level, sampled in IDLE and GAME_OVER only
- i_player_hit  in  1  player sprite covers current pixel
- i_barrier_hit  in  1  barrier sprite o_sprite_hit
- i_in_position  in  1  barrier in_position
- o_active  out  1  drives barrier active
- o_collision  out  1  one-cycle pulse on collision
- o_dodged  out  1  one-cycle pulse on dodge
- o_score  out  SCORE_W  barriers dodged, saturating
- o_lives  out  3  remaining lives
- o_game_over  out  1  high in GAME_OVER
- o_state  out  3  encoding: IDLE=0, COOLDOWN=1, APPROACH=2, ARMED=3, HOLD=4, GAME_OVER=5

Behaviour:
- All registers update on rising i_clk. i_rst is synchronous and active-high.
- Reset values:
  - state=IDLE, o_active=0, o_collision=0, o_dodged=0
  - o_score=0, o_lives=LIVES_INIT, o_game_over=0
  - vs_q=1, so there is no spurious tick after reset
  - LFSR=16'hACE1
- Frame tick: frame_tick = i_v_sync & ~vs_q, where vs_q is i_v_sync registered. Exactly one cycle per rising edge.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle and never reaches zero.
  - Cooldown load value = COOLDOWN_MIN + LFSR[COOLDOWN_RAND_BITS-1:0], sampled on the cycle of the load.
- o_active is registered: 1 in APPROACH and ARMED, 0 in all other states.
- IDLE:
  - i_start=1 -> COOLDOWN, load cooldown, score=0, lives=LIVES_INIT.
- COOLDOWN:
  - Counter decrements on each frame_tick.
  - A frame_tick arriving with counter==0 -> APPROACH.
- APPROACH:
  - i_in_position=1 -> ARMED, frame counter=0.
  - Hit inputs are ignored.
- ARMED:
  - Priority 1, collision: i_player_hit & i_barrier_hit.
    - o_collision=1 for one cycle; lives decrements.
    - If the new lives==0 -> GAME_OVER.
    - Otherwise -> HOLD with counter=HIT_HOLD.
  - Priority 2, dodge by fall: i_in_position=0.
    - o_dodged=1 for one cycle; score increments, saturating at all-ones.
    - -> COOLDOWN with cooldown reloaded.
  - Priority 3, frame count: on frame_tick the counter increments. Reaching ARMED_TIMEOUT is treated as a dodge, identical to priority 2.
  - Collision wins over a simultaneous in_position fall or timeout.
- HOLD:
  - o_active=0, so the barrier resets to its start position.
  - Counter decrements on frame_tick; a tick with counter==0 -> COOLDOWN, reload.
- GAME_OVER:
  - o_game_over=1, o_active=0.
  - i_start=1 -> COOLDOWN, score=0, lives=LIVES_INIT.
- i_start is ignored outside IDLE and GAME_OVER.
- Reset mid-operation returns all outputs to reset values on the next edge; o_active drops immediately.
- Pulses never overlap, and at most one resolution (collision or dodge) occurs per barrier.

Test Plan:
1. Reset, including with i_v_sync held high during reset -> all outputs at reset values, state=IDLE. No COOLDOWN decrement occurs on the first cycle after reset.
2. i_start pulse, then 100 v_sync edges -> o_active rises after N+1 ticks, where N = 30 + LFSR[5:0] captured at start. N must lie within 30..93.
3. In APPROACH, raise i_in_position for 5 frames, then drop it -> o_dodged pulses exactly once, o_score=1, o_active=0 next cycle, state=COOLDOWN.
4. In ARMED, drive i_player_hit=i_barrier_hit=1 for one pixel -> o_collision single pulse, o_lives=2, o_active=0 for 61 ticks, then COOLDOWN.
5. Three collisions -> o_game_over=1, o_lives=0, o_active stays 0. i_start -> o_score=0, o_lives=3, state=COOLDOWN.
6. Collision and i_in_position fall on the same cycle -> only o_collision pulses. Separately, ARMED with in_position held for 120 ticks -> forced o_dodged. Score preloaded to 255 plus a dodge -> stays 255.
